// File: rtl/bp_pkg.sv
// bp_pkg: shared types and helpers for the fetch-side branch predictor.
//   - 2-bit counter encodings and the reset/allocation values
//   - bp_entry_t: one BTB entry (valid, tag, ctr, target)
//   - bp_index / bp_tag: PC slicing for a table of 2**idx_w entries
package bp_pkg;

    localparam int PC_W  = 32;
    // Widest tag any legal table depth can need (ENTRIES >= 4 gives IDX_W >= 2).
    localparam int TAG_W = 28;

    typedef logic [1:0] ctr_t;

    localparam ctr_t CTR_SNT = 2'b00;
    localparam ctr_t CTR_WNT = 2'b01;
    localparam ctr_t CTR_WT  = 2'b10;
    localparam ctr_t CTR_ST  = 2'b11;

    localparam ctr_t CTR_RESET     = CTR_WNT;
    localparam ctr_t CTR_ALLOC_BR  = CTR_WT;
    localparam ctr_t CTR_ALLOC_JMP = CTR_ST;

    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
        ctr_t             ctr;
        logic [PC_W-1:0]  target;
    } bp_entry_t;

    // Word-aligned index: pc[idx_w+1:2], returned zero-extended.
    function automatic logic [PC_W-1:0] bp_index(input logic [PC_W-1:0] pc,
                                                 input int unsigned     idx_w);
        return (pc >> 2) & ((32'd1 << idx_w) - 32'd1);
    endfunction

    // Tag: pc[31:idx_w+2], zero-extended into TAG_W bits.
    function automatic logic [TAG_W-1:0] bp_tag(input logic [PC_W-1:0] pc,
                                                input int unsigned     idx_w);
        logic [PC_W-1:0] shifted;
        shifted = pc >> (idx_w + 2);
        return shifted[TAG_W-1:0];
    endfunction

endpackage

// File: rtl/branch_predictor_sat_counter2.sv
// sat_counter2: combinational next state of a 2-bit saturating counter.
//   ctr      in  2 - current counter value
//   taken    in  1 - outcome: count up when 1, down when 0
//   force_st in  1 - unconditional jump: jump straight to strongly-taken
//   ctr_next out 2 - next counter value
module sat_counter2
    import bp_pkg::*;
(
    input  logic [1:0] ctr,
    input  logic       taken,
    input  logic       force_st,
    output logic [1:0] ctr_next
);

    always_comb begin
        ctr_next = ctr;
        if (force_st) begin
            ctr_next = CTR_ST;
        end else if (taken) begin
            if (ctr != CTR_ST) ctr_next = ctr + 2'd1;
        end else begin
            if (ctr != CTR_SNT) ctr_next = ctr - 2'd1;
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// branch_predictor: BTB with 2-bit counters, direct-mapped, register array.
//   clk, rst_n          - clock (rising edge), async active-low reset
//   if_pc               - fetch PC, looked up combinationally
//   pred_taken/target   - same-cycle prediction for if_pc (target 0 if not taken)
//   ex_update..ex_mispredict - EX-stage branch resolution used for training
//   bp_clear            - invalidate every entry at the next edge
//   branch_count        - saturating count of resolved branches
//   mispredict_count    - saturating count of mispredicted branches
module branch_predictor
    import bp_pkg::*;
#(
    parameter int ENTRIES = 64,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      if_pc,
    output logic             pred_taken,
    output logic [31:0]      pred_target,
    input  logic             ex_update,
    input  logic             ex_is_jump,
    input  logic [31:0]      ex_pc,
    input  logic             ex_taken,
    input  logic [31:0]      ex_target,
    input  logic             ex_mispredict,
    input  logic             bp_clear,
    output logic [CNT_W-1:0] branch_count,
    output logic [CNT_W-1:0] mispredict_count
);

    localparam int IDX_W = $clog2(ENTRIES);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    bp_entry_t        table_q [ENTRIES];
    bp_entry_t        table_d [ENTRIES];
    logic [CNT_W-1:0] branch_count_q, branch_count_d;
    logic [CNT_W-1:0] mispredict_count_q, mispredict_count_d;

    // Lookup: purely combinational from registered state, so a same-cycle
    // update to the same index is not visible until the next cycle.
    logic [IDX_W-1:0] if_idx;
    logic [TAG_W-1:0] if_tag;
    logic             if_hit;

    assign if_idx      = IDX_W'(bp_index(if_pc, IDX_W));
    assign if_tag      = bp_tag(if_pc, IDX_W);
    assign if_hit      = table_q[if_idx].valid && (table_q[if_idx].tag == if_tag);
    assign pred_taken  = if_hit && table_q[if_idx].ctr[1];
    assign pred_target = pred_taken ? table_q[if_idx].target : 32'd0;

    // Training path.
    logic [IDX_W-1:0] ex_idx;
    logic [TAG_W-1:0] ex_tag;
    logic             ex_hit;
    logic [1:0]       ex_ctr_next;

    assign ex_idx = IDX_W'(bp_index(ex_pc, IDX_W));
    assign ex_tag = bp_tag(ex_pc, IDX_W);
    assign ex_hit = table_q[ex_idx].valid && (table_q[ex_idx].tag == ex_tag);

    sat_counter2 u_sat_counter2 (
        .ctr      (table_q[ex_idx].ctr),
        .taken    (ex_taken),
        .force_st (ex_is_jump),
        .ctr_next (ex_ctr_next)
    );

    always_comb begin
        table_d = table_q;
        if (bp_clear) begin
            // Clear beats any update in the same cycle.
            for (int i = 0; i < ENTRIES; i++) table_d[i].valid = 1'b0;
        end else if (ex_update) begin
            if (ex_hit) begin
                table_d[ex_idx].ctr = ex_ctr_next;
                // A not-taken branch keeps its last known target.
                if (ex_is_jump || ex_taken) table_d[ex_idx].target = ex_target;
            end else if (ex_taken) begin
                // Allocate on a taken miss, evicting whatever aliased here.
                table_d[ex_idx].valid  = 1'b1;
                table_d[ex_idx].tag    = ex_tag;
                table_d[ex_idx].target = ex_target;
                table_d[ex_idx].ctr    = ex_is_jump ? CTR_ALLOC_JMP : CTR_ALLOC_BR;
            end
        end
    end

    always_comb begin
        branch_count_d     = branch_count_q;
        mispredict_count_d = mispredict_count_q;
        if (ex_update) begin
            branch_count_d = sat_inc(branch_count_q);
            if (ex_mispredict) mispredict_count_d = sat_inc(mispredict_count_q);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                table_q[i].valid  <= 1'b0;
                table_q[i].tag    <= '0;
                table_q[i].ctr    <= CTR_RESET;
                table_q[i].target <= '0;
            end
            branch_count_q     <= '0;
            mispredict_count_q <= '0;
        end else begin
            table_q            <= table_d;
            branch_count_q     <= branch_count_d;
            mispredict_count_q <= mispredict_count_d;
        end
    end

    assign branch_count     = branch_count_q;
    assign mispredict_count = mispredict_count_q;

endmodule

// File: tb/tb_branch_predictor.sv
module tb_branch_predictor;

    localparam int ENTRIES = 64;
    localparam int CNT_W   = 4;
    localparam int CNT_MAX = 15;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [31:0]      if_pc;
    logic             pred_taken;
    logic [31:0]      pred_target;
    logic             ex_update, ex_is_jump, ex_taken, ex_mispredict, bp_clear;
    logic [31:0]      ex_pc, ex_target;
    logic [CNT_W-1:0] branch_count, mispredict_count;

    branch_predictor #(.ENTRIES(ENTRIES), .CNT_W(CNT_W)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .if_pc            (if_pc),
        .pred_taken       (pred_taken),
        .pred_target      (pred_target),
        .ex_update        (ex_update),
        .ex_is_jump       (ex_is_jump),
        .ex_pc            (ex_pc),
        .ex_taken         (ex_taken),
        .ex_target        (ex_target),
        .ex_mispredict    (ex_mispredict),
        .bp_clear         (bp_clear),
        .branch_count     (branch_count),
        .mispredict_count (mispredict_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: one record per table slot, counters as plain integers.
    bit          m_valid [ENTRIES];
    logic [31:0] m_tag   [ENTRIES];
    int          m_ctr   [ENTRIES];
    logic [31:0] m_tgt   [ENTRIES];
    int          m_bc, m_mc;

    logic        obs_taken, exp_taken;
    logic [31:0] obs_target, exp_target;

    task automatic model_reset();
        for (int i = 0; i < ENTRIES; i++) begin
            m_valid[i] = 0; m_tag[i] = 0; m_ctr[i] = 1; m_tgt[i] = 0;
        end
        m_bc = 0; m_mc = 0;
    endtask

    task automatic model_predict(input logic [31:0] pc, output logic tk, output logic [31:0] tg);
        int idx;
        idx = int'((pc / 4) % ENTRIES);
        tk  = m_valid[idx] && (m_tag[idx] == pc / (4 * ENTRIES)) && (m_ctr[idx] >= 2);
        tg  = tk ? m_tgt[idx] : 32'd0;
    endtask

    task automatic model_update(input bit upd, jmp, input logic [31:0] epc,
                                input bit tk, input logic [31:0] etg, input bit misp, clr);
        int idx;
        logic [31:0] tag;
        if (upd) begin
            if (m_bc < CNT_MAX) m_bc++;
            if (misp && m_mc < CNT_MAX) m_mc++;
        end
        idx = int'((epc / 4) % ENTRIES);
        tag = epc / (4 * ENTRIES);
        if (clr) begin
            for (int i = 0; i < ENTRIES; i++) m_valid[i] = 0;
        end else if (upd) begin
            if (m_valid[idx] && m_tag[idx] == tag) begin
                if (jmp) begin
                    m_ctr[idx] = 3; m_tgt[idx] = etg;
                end else if (tk) begin
                    m_ctr[idx] = (m_ctr[idx] < 3) ? m_ctr[idx] + 1 : 3; m_tgt[idx] = etg;
                end else begin
                    m_ctr[idx] = (m_ctr[idx] > 0) ? m_ctr[idx] - 1 : 0;
                end
            end else if (tk) begin
                m_valid[idx] = 1; m_tag[idx] = tag; m_tgt[idx] = etg;
                m_ctr[idx] = jmp ? 3 : 2;
            end
        end
    endtask

    // One clock: drive, sample the lookup mid-cycle, advance the model, take the edge.
    task automatic step(input logic [31:0] ipc, input bit upd, jmp, input logic [31:0] epc,
                        input bit tk, input logic [31:0] etg, input bit misp, clr);
        if_pc = ipc; ex_update = upd; ex_is_jump = jmp; ex_pc = epc;
        ex_taken = tk; ex_target = etg; ex_mispredict = misp; bp_clear = clr;
        @(negedge clk);
        obs_taken  = pred_taken;
        obs_target = pred_target;
        model_predict(ipc, exp_taken, exp_target);
        model_update(upd, jmp, epc, tk, etg, misp, clr);
        @(posedge clk);
        #1;
        ex_update = 0; bp_clear = 0; ex_mispredict = 0;
    endtask

    task automatic test_reset();
        rst_n = 0; if_pc = 32'h100; ex_update = 0; ex_is_jump = 0; ex_pc = 0;
        ex_taken = 0; ex_target = 0; ex_mispredict = 0; bp_clear = 0;
        model_reset();
        #12;
        n_checks++; if (pred_taken !== 1'b0) $display("FAIL reset_pred_taken got %b want 0", pred_taken); else n_pass++;
        n_checks++; if (pred_target !== 32'd0) $display("FAIL reset_pred_target got %h want 0", pred_target); else n_pass++;
        n_checks++; if (branch_count !== 4'd0) $display("FAIL reset_branch_count got %0d want 0", branch_count); else n_pass++;
        n_checks++; if (mispredict_count !== 4'd0) $display("FAIL reset_mispredict_count got %0d want 0", mispredict_count); else n_pass++;
        rst_n = 1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic_train();
        step(32'h0, 1, 0, 32'h100, 1, 32'h140, 1, 0);
        step(32'h100, 0, 0, 0, 0, 0, 0, 0);
        n_checks++; if (obs_taken !== 1'b1) $display("FAIL basic_taken got %b want 1", obs_taken); else n_pass++;
        n_checks++; if (obs_target !== 32'h140) $display("FAIL basic_target got %h want 00000140", obs_target); else n_pass++;
    endtask

    task automatic test_alias();
        step(32'h200, 0, 0, 0, 0, 0, 0, 0);
        n_checks++; if (obs_taken !== 1'b0) $display("FAIL alias_miss got %b want 0", obs_taken); else n_pass++;
        step(32'h0, 1, 0, 32'h200, 1, 32'h300, 0, 0);
        step(32'h100, 0, 0, 0, 0, 0, 0, 0);
        n_checks++; if (obs_taken !== 1'b0) $display("FAIL alias_evicted got %b want 0", obs_taken); else n_pass++;
        step(32'h200, 0, 0, 0, 0, 0, 0, 0);
        n_checks++; if (obs_taken !== 1'b1 || obs_target !== 32'h300)
            $display("FAIL alias_new got %b/%h want 1/00000300", obs_taken, obs_target); else n_pass++;
    endtask

    task automatic test_hysteresis();
        logic want [4];
        want[0] = 1; want[1] = 0; want[2] = 0; want[3] = 0;
        for (int i = 0; i < 3; i++) step(32'h0, 1, 0, 32'h40, 1, 32'h44, 0, 0);
        for (int i = 0; i < 4; i++) begin
            step(32'h0, 1, 0, 32'h40, 0, 32'h0, 1, 0);
            step(32'h40, 0, 0, 0, 0, 0, 0, 0);
            n_checks++; if (obs_taken !== want[i])
                $display("FAIL hyst_nt%0d got %b want %b", i + 1, obs_taken, want[i]); else n_pass++;
            n_checks++; if (obs_taken !== exp_taken)
                $display("FAIL hyst_model%0d got %b want %b", i + 1, obs_taken, exp_taken); else n_pass++;
        end
    endtask

    task automatic test_same_cycle_raw();
        step(32'h80, 1, 0, 32'h80, 1, 32'h90, 0, 0);
        n_checks++; if (obs_taken !== 1'b0) $display("FAIL raw_same_cycle got %b want 0", obs_taken); else n_pass++;
        step(32'h80, 0, 0, 0, 0, 0, 0, 0);
        n_checks++; if (obs_taken !== 1'b1 || obs_target !== 32'h90)
            $display("FAIL raw_next_cycle got %b/%h want 1/00000090", obs_taken, obs_target); else n_pass++;
    endtask

    task automatic test_clear_vs_update();
        logic [31:0] pcs [4];
        int bc_before;
        pcs[0] = 32'h10; pcs[1] = 32'h200; pcs[2] = 32'h80; pcs[3] = 32'h40;
        step(32'h0, 1, 1, 32'h40, 1, 32'h48, 0, 0); // re-train 0x40 as a jump
        bc_before = m_bc;
        step(32'h0, 1, 0, 32'h10, 1, 32'h20, 0, 1);
        n_checks++; if (int'(branch_count) !== bc_before + 1)
            $display("FAIL clear_branch_count got %0d want %0d", branch_count, bc_before + 1); else n_pass++;
        for (int i = 0; i < 4; i++) begin
            step(pcs[i], 0, 0, 0, 0, 0, 0, 0);
            n_checks++; if (obs_taken !== 1'b0 || obs_target !== 32'd0)
                $display("FAIL clear_pc_%h got %b/%h want 0/00000000", pcs[i], obs_taken, obs_target); else n_pass++;
        end
    endtask

    task automatic test_stats_and_reset();
        for (int i = 0; i < 20; i++) step(32'h0, 1, 0, 32'h500, 1, 32'h600, 1, 0);
        n_checks++; if (branch_count !== 4'd15) $display("FAIL stats_branch_sat got %0d want 15", branch_count); else n_pass++;
        n_checks++; if (mispredict_count !== 4'd15) $display("FAIL stats_misp_sat got %0d want 15", mispredict_count); else n_pass++;
        step(32'h500, 0, 0, 0, 0, 0, 0, 0);
        n_checks++; if (obs_taken !== 1'b1 || obs_target !== 32'h600)
            $display("FAIL stats_trained got %b/%h want 1/00000600", obs_taken, obs_target); else n_pass++;
        // Mid-cycle reset pulse with if_pc still on a trained entry.
        if_pc = 32'h500;
        rst_n = 0;
        #2;
        n_checks++; if (pred_taken !== 1'b0 || pred_target !== 32'd0)
            $display("FAIL async_reset_pred got %b/%h want 0/00000000", pred_taken, pred_target); else n_pass++;
        n_checks++; if (branch_count !== 4'd0 || mispredict_count !== 4'd0)
            $display("FAIL async_reset_counts got %0d/%0d want 0/0", branch_count, mispredict_count); else n_pass++;
        model_reset();
        #1 rst_n = 1;
        step(32'h500, 0, 0, 0, 0, 0, 0, 0);
        n_checks++; if (obs_taken !== 1'b0) $display("FAIL post_reset_pred got %b want 0", obs_taken); else n_pass++;
    endtask

    task automatic test_back_to_back_random();
        logic [31:0] ipc, epc, etg;
        bit upd, jmp, tk, misp, clr;
        for (int i = 0; i < 400; i++) begin
            ipc  = ($urandom_range(0, 3) << 8) | ($urandom_range(0, 7) << 2);
            epc  = ($urandom_range(0, 3) << 8) | ($urandom_range(0, 7) << 2);
            etg  = $urandom & 32'hFFFF_FFFC;
            upd  = ($urandom_range(0, 3) != 0);
            jmp  = ($urandom_range(0, 4) == 0);
            tk   = jmp ? 1'b1 : 1'($urandom_range(0, 1));
            misp = 1'($urandom_range(0, 1));
            clr  = ($urandom_range(0, 49) == 0);
            if (i == 200) begin
                // Pull counts back under saturation for the second half.
                rst_n = 0; model_reset(); #1 rst_n = 1;
            end
            step(ipc, upd, jmp, epc, tk, etg, misp, clr);
            n_checks++; if (obs_taken !== exp_taken || obs_target !== exp_target)
                $display("FAIL rand_pred[%0d] pc=%h got %b/%h want %b/%h",
                         i, ipc, obs_taken, obs_target, exp_taken, exp_target); else n_pass++;
            n_checks++; if (int'(branch_count) !== m_bc || int'(mispredict_count) !== m_mc)
                $display("FAIL rand_counts[%0d] got %0d/%0d want %0d/%0d",
                         i, branch_count, mispredict_count, m_bc, m_mc); else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_basic_train();
        test_alias();
        test_hysteresis();
        test_same_cycle_raw();
        test_clear_vs_update();
        test_stats_and_reset();
        test_back_to_back_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
